// File: rtl/ahb_sram_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave_if
//   AHB-Lite bus bundle between a single master and ahb_sram_slave.
//
//   Handshake: an address phase is taken by the slave in any cycle where
//   hsel & hready & htrans[1] are high at the rising clock edge.  The data
//   phase that follows ends in the first cycle with hreadyout=1; hrdata and
//   hresp are meaningful only in that cycle, and the master keeps hwdata (and
//   any waiting address phase) stable until then.
//
//   Signals (master -> slave):
//     hsel       slave select
//     haddr      byte address
//     htrans     00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//     hwrite     1 = write
//     hsize      0 byte, 1 half, 2 word
//     hburst     burst type (carried, not interpreted)
//     hwdata     write data, little-endian byte lanes
//     hready     bus-level HREADY (previous transfer complete)
//   Signals (slave -> master):
//     hrdata     read data
//     hreadyout  slave transfer-done
//     hresp      00 OKAY, 01 ERROR
//   With AHB_SRAM_CONSOLE_EN defined (slave -> observer):
//     console_valid  one-cycle strobe per console byte
//     console_data   console byte
// ---------------------------------------------------------------------------
interface ahb_sram_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic [1:0]  hresp;
`ifdef AHB_SRAM_CONSOLE_EN
    logic        console_valid;
    logic [7:0]  console_data;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        output hrdata, hreadyout, hresp, console_valid, console_data
    );
    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        input  hrdata, hreadyout, hresp, console_valid, console_data
    );
`else
    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        output hrdata, hreadyout, hresp
    );
    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        input  hrdata, hreadyout, hresp
    );
`endif
endinterface

// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
//   AHB-Lite responder backed by a word-organised SRAM.  Byte, halfword and
//   word transfers, a fixed number of wait states on every OKAY data phase,
//   two-cycle ERROR responses for illegal accesses, and a write-to-read
//   bypass so a read pipelined behind a write to the same word sees the new
//   bytes.  One transfer per cycle when WAIT_STATES = 0.
//
//   Optional feature macro: AHB_SRAM_CONSOLE_EN
//     Defined: CONSOLE_ADDR is a byte register; byte writes emit one
//     console_valid strobe carrying the addressed byte lane, byte reads
//     return 0, non-byte accesses get ERROR.  Console transfers never wait.
//     Undefined: CONSOLE_ADDR is ordinary out-of-range space (ERROR).
//
//   Ports:
//     i_hclk      bus clock, all state on the rising edge
//     i_hreset_n  asynchronous active-low reset
//     bus         ahb_sram_slave_if.slave (address/data/response signals)
//     dbg_state   current FSM state (0 IDLE, 1 WAIT, 2 ERR1, 3 ERR2)
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
    parameter int unsigned MEM_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
    parameter int unsigned WAIT_STATES  = 0,
    parameter logic [31:0] CONSOLE_ADDR = 32'h8000_0103
) (
    input  logic                  i_hclk,
    input  logic                  i_hreset_n,
    ahb_sram_slave_if.slave       bus,
    output logic [1:0]            dbg_state
);

    localparam int unsigned AW          = $clog2(MEM_WORDS);
    localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);
    localparam logic [3:0]  WAIT_LAST   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_ERROR  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t         state;
    logic [3:0]     wait_cnt;
    logic           ready_r;
    logic [1:0]     resp_r;
    logic [31:0]    rdata_r;

    // Data-phase bookkeeping for a pending SRAM write.
    logic           dp_wr;
    logic [AW-1:0]  dp_idx;
    logic [3:0]     dp_be;

    logic [31:0]    mem [0:MEM_WORDS-1];

    // Address-phase decode.
    logic           accept;
    logic [31:0]    offset;
    logic           in_range;
    logic           aligned;
    logic           mem_legal;
    logic           legal;
    logic           is_con;
    logic [AW-1:0]  acc_idx;
    logic [3:0]     acc_be;
    logic           we;
    logic [31:0]    rd_word;
    logic [31:0]    merged;

    assign accept   = bus.hsel & bus.hready & bus.htrans[1];
    // Modular subtraction: anything below BASE_ADDR wraps to a huge offset.
    assign offset   = bus.haddr - BASE_ADDR;
    assign in_range = (offset[31:2] < MEM_WORDS_W);
    assign acc_idx  = offset[AW+1:2];

    always_comb begin
        aligned = 1'b0;
        acc_be  = 4'hF;
        case (bus.hsize)
            3'd0: begin
                aligned = 1'b1;
                acc_be  = 4'b0001 << bus.haddr[1:0];
            end
            3'd1: begin
                aligned = ~bus.haddr[0];
                acc_be  = 4'b0011 << bus.haddr[1:0];
            end
            3'd2: begin
                aligned = (bus.haddr[1:0] == 2'b00);
                acc_be  = 4'hF;
            end
            default: begin
                aligned = 1'b0;
                acc_be  = 4'hF;
            end
        endcase
    end

    assign mem_legal = in_range & aligned;

`ifdef AHB_SRAM_CONSOLE_EN
    logic       dp_con;
    logic [1:0] dp_lane;
    logic       con_valid_r;
    logic [7:0] con_data_r;

    // The console register wins over SRAM decode if the two ever overlap.
    assign is_con = (bus.haddr == CONSOLE_ADDR);
    assign legal  = is_con ? (bus.hsize == 3'd0) : mem_legal;

    assign bus.console_valid = con_valid_r;
    assign bus.console_data  = con_data_r;
`else
    assign is_con = 1'b0;
    assign legal  = mem_legal;
`endif

    // A write commits at the end of its completing data-phase cycle.
    assign we      = ready_r & dp_wr;
    assign rd_word = mem[acc_idx];

    // Read accepted on the edge a same-word write commits: take new lanes.
    always_comb begin
        merged = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (we && (dp_idx == acc_idx) && dp_be[i]) begin
                merged[8*i +: 8] = bus.hwdata[8*i +: 8];
            end
        end
    end

    // SRAM array: no reset, byte-lane write enables.
    always_ff @(posedge i_hclk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (dp_be[i]) begin
                    mem[dp_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            ready_r  <= 1'b1;
            resp_r   <= RESP_OKAY;
            rdata_r  <= 32'h0;
            dp_wr    <= 1'b0;
            dp_idx   <= '0;
            dp_be    <= 4'h0;
`ifdef AHB_SRAM_CONSOLE_EN
            dp_con      <= 1'b0;
            dp_lane     <= 2'd0;
            con_valid_r <= 1'b0;
            con_data_r  <= 8'h0;
`endif
        end else begin
`ifdef AHB_SRAM_CONSOLE_EN
            con_valid_r <= 1'b0;
            if (ready_r && dp_con) begin
                con_valid_r <= 1'b1;
                con_data_r  <= bus.hwdata[{dp_lane, 3'b000} +: 8];
            end
`endif
            if (ready_r) begin
                // Current data phase (if any) completes this cycle, so a new
                // address phase may be taken: IDLE, WAIT-done or ERR2.
                if (accept) begin
                    dp_wr  <= legal & bus.hwrite & ~is_con;
                    dp_idx <= acc_idx;
                    dp_be  <= acc_be;
`ifdef AHB_SRAM_CONSOLE_EN
                    dp_con  <= legal & bus.hwrite & is_con;
                    dp_lane <= bus.haddr[1:0];
`endif
                    if (!legal) begin
                        state   <= ST_ERR1;
                        ready_r <= 1'b0;
                        resp_r  <= RESP_ERROR;
                    end else begin
                        resp_r <= RESP_OKAY;
                        if (WAIT_STATES == 0 || is_con) begin
                            state   <= ST_IDLE;
                            ready_r <= 1'b1;
                        end else begin
                            state    <= ST_WAIT;
                            ready_r  <= 1'b0;
                            wait_cnt <= 4'd0;
                        end
                        if (!bus.hwrite) begin
                            rdata_r <= is_con ? 32'h0 : merged;
                        end
                    end
                end else begin
                    dp_wr   <= 1'b0;
`ifdef AHB_SRAM_CONSOLE_EN
                    dp_con  <= 1'b0;
`endif
                    state   <= ST_IDLE;
                    ready_r <= 1'b1;
                    resp_r  <= RESP_OKAY;
                end
            end else begin
                case (state)
                    ST_WAIT: begin
                        if (wait_cnt == WAIT_LAST) begin
                            ready_r <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
                    end
                    ST_ERR1: begin
                        state   <= ST_ERR2;
                        ready_r <= 1'b1;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        ready_r <= 1'b1;
                        resp_r  <= RESP_OKAY;
                    end
                endcase
            end
        end
    end

    assign bus.hrdata    = rdata_r;
    assign bus.hreadyout = ready_r;
    assign bus.hresp     = resp_r;
    assign dbg_state     = state;

    // Inputs carried by the bus but not interpreted here.
`ifdef AHB_SRAM_CONSOLE_EN
    logic unused_bits;
    assign unused_bits = ^{bus.hburst, bus.htrans[0], offset[1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{bus.hburst, bus.htrans[0], offset[1:0], CONSOLE_ADDR};
`endif

endmodule

// File: tb/tb_ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_slave
//   Two instances of ahb_sram_slave (WAIT_STATES = 0 and 3) share one
//   pipelined AHB driver; sel picks which one is addressed.  Directed table
//   vectors, hand-written wait/reset sequences, then random transfers
//   predicted by a byte-level memory model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ahb_sram_slave;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] CON  = 32'h8000_0103;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bus wiring ----------------
    logic        sel;
    logic        hsel_d;
    logic [31:0] haddr_d;
    logic [1:0]  htrans_d;
    logic        hwrite_d;
    logic [2:0]  hsize_d;
    logic [31:0] hwdata_d;
    logic [1:0]  dbg0, dbg3;

    ahb_sram_slave_if bus0();
    ahb_sram_slave_if bus3();

    assign bus0.hsel   = hsel_d & ~sel;
    assign bus0.haddr  = haddr_d;
    assign bus0.htrans = htrans_d;
    assign bus0.hwrite = hwrite_d;
    assign bus0.hsize  = hsize_d;
    assign bus0.hburst = 3'b000;
    assign bus0.hwdata = hwdata_d;
    assign bus0.hready = bus0.hreadyout;

    assign bus3.hsel   = hsel_d & sel;
    assign bus3.haddr  = haddr_d;
    assign bus3.htrans = htrans_d;
    assign bus3.hwrite = hwrite_d;
    assign bus3.hsize  = hsize_d;
    assign bus3.hburst = 3'b000;
    assign bus3.hwdata = hwdata_d;
    assign bus3.hready = bus3.hreadyout;

    ahb_sram_slave #(.WAIT_STATES(0)) dut0 (
        .i_hclk(clk), .i_hreset_n(rst_n), .bus(bus0.slave), .dbg_state(dbg0)
    );
    ahb_sram_slave #(.WAIT_STATES(3)) dut3 (
        .i_hclk(clk), .i_hreset_n(rst_n), .bus(bus3.slave), .dbg_state(dbg3)
    );

    logic        cur_ready;
    logic [31:0] cur_rdata;
    logic [1:0]  cur_resp;
    assign cur_ready = sel ? bus3.hreadyout : bus0.hreadyout;
    assign cur_rdata = sel ? bus3.hrdata    : bus0.hrdata;
    assign cur_resp  = sel ? bus3.hresp     : bus0.hresp;

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          waits;
    } rsp_t;

    typedef struct {
        xfer_t       x;
        logic [31:0] rd;
        logic [1:0]  resp;
        int          waits;
        bit          chk_rd;
    } vec_t;

    xfer_t      xq[$];
    rsp_t       rq[$];
    rsp_t       exp_q[$];
    bit         exp_chk_q[$];
    logic [7:0] exp_con_q[$];
    logic [7:0] got_con_q[$];
    int         last_cycles;

    logic [31:0] mdl [0:1023];

`ifdef AHB_SRAM_CONSOLE_EN
    always @(negedge clk) begin
        if (bus0.console_valid) got_con_q.push_back(bus0.console_data);
        if (bus3.console_valid) got_con_q.push_back(bus3.console_data);
    end
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        hsel_d   = 1'b0;
        htrans_d = 2'b00;
        haddr_d  = 32'h0;
        hwrite_d = 1'b0;
        hsize_d  = 3'd0;
        hwdata_d = 32'h0;
    endtask

    // ---------------- driver: pipelined master over xq ----------------
    task automatic drive_all();
        int    i;
        bit    dp_v;
        xfer_t dp;
        int    waits;
        int    cyc;
        int    n;
        rsp_t  r;
        n = xq.size();
        i = 0;
        dp_v = 1'b0;
        waits = 0;
        cyc = 0;
        dp = '{default: '0};
        rq.delete();
        while (i < n || dp_v) begin
            if (i < n) begin
                hsel_d   = 1'b1;
                htrans_d = 2'b10;
                haddr_d  = xq[i].addr;
                hwrite_d = xq[i].wr;
                hsize_d  = xq[i].size;
            end else begin
                hsel_d   = 1'b0;
                htrans_d = 2'b00;
                haddr_d  = 32'h0;
                hwrite_d = 1'b0;
                hsize_d  = 3'd0;
            end
            hwdata_d = dp_v ? dp.wdata : 32'h0;
            @(negedge clk);
            cyc++;
            if (cur_ready) begin
                if (dp_v) begin
                    r.rdata = cur_rdata;
                    r.resp  = cur_resp;
                    r.waits = waits;
                    rq.push_back(r);
                end
                dp_v = (i < n);
                if (i < n) begin
                    dp = xq[i];
                    i++;
                end
                waits = 0;
            end else begin
                waits++;
                if (waits > 40) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL hready_timeout: got %0d low cycles, required at most 40", waits);
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        bus_idle();
        last_cycles = cyc;
    endtask

    // ---------------- reference model ----------------
    task automatic predict(input xfer_t x, input int w, output rsp_t e, output bit chk_rd);
        logic [31:0] off;
        bit          con;
        bit          ok;
        int          b0;
        int          nb;
        int          idx;
        off = x.addr - BASE;
`ifdef AHB_SRAM_CONSOLE_EN
        con = (x.addr == CON);
`else
        con = 1'b0;
`endif
        if (con) begin
            ok = (x.size == 3'd0);
        end else begin
            ok = (off < 32'h1000) && (x.size <= 3'd2) &&
                 ((x.addr % (32'd1 << x.size)) == 32'd0);
        end
        e.rdata = 32'h0;
        chk_rd  = 1'b0;
        if (!ok) begin
            e.resp  = 2'b01;
            e.waits = 1;
        end else begin
            e.resp  = 2'b00;
            e.waits = con ? 0 : w;
            b0  = int'(x.addr % 4);
            nb  = 1 << x.size;
            idx = int'(off >> 2);
            if (!x.wr) begin
                chk_rd  = 1'b1;
                e.rdata = con ? 32'h0 : mdl[idx];
            end else if (con) begin
                exp_con_q.push_back(x.wdata[8*b0 +: 8]);
            end else begin
                for (int b = b0; b < b0 + nb; b++) begin
                    mdl[idx][8*b +: 8] = x.wdata[8*b +: 8];
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k >= rq.size()) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s_missing[%0d]: got %0d responses, required %0d", tag, k, rq.size(), exp_q.size());
                break;
            end
            check($sformatf("%s_resp[%0d]", tag, k), 32'(rq[k].resp), 32'(exp_q[k].resp));
            check($sformatf("%s_waits[%0d]", tag, k), 32'(rq[k].waits), 32'(exp_q[k].waits));
            if (exp_chk_q[k]) begin
                check($sformatf("%s_rdata[%0d]", tag, k), rq[k].rdata, exp_q[k].rdata);
            end
        end
    endtask

    task automatic compare_console(input string tag);
        check({tag, "_con_count"}, 32'(got_con_q.size()), 32'(exp_con_q.size()));
        for (int k = 0; k < exp_con_q.size() && k < got_con_q.size(); k++) begin
            check($sformatf("%s_con_data[%0d]", tag, k), 32'(got_con_q[k]), 32'(exp_con_q[k]));
        end
        got_con_q.delete();
        exp_con_q.delete();
    endtask

    function automatic vec_t mk(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rd,
                                input logic [1:0] resp, input int waits, input bit chk_rd);
        vec_t v;
        v.x.wr    = wr;
        v.x.size  = size;
        v.x.addr  = addr;
        v.x.wdata = wdata;
        v.rd      = rd;
        v.resp    = resp;
        v.waits   = waits;
        v.chk_rd  = chk_rd;
        return v;
    endfunction

    task automatic random_run(input bit which, input int w, input string tag);
        xfer_t x;
        rsp_t  e;
        bit    c;
        int    pick;
        int    word;
        sel = which;
        xq.delete();
        exp_q.delete();
        exp_chk_q.delete();
        // Defined contents for the random window (words 0x40..0x4F).
        for (int k = 0; k < 16; k++) begin
            x.wr = 1'b1;
            x.size = 3'd2;
            x.addr = BASE + 32'h100 + 32'(4 * k);
            x.wdata = $urandom();
            predict(x, w, e, c);
            xq.push_back(x);
            exp_q.push_back(e);
            exp_chk_q.push_back(c);
        end
        for (int k = 0; k < 40; k++) begin
            x.wr    = 1'($urandom_range(0, 1));
            x.wdata = $urandom();
            x.size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            pick    = $urandom_range(0, 9);
            word    = $urandom_range(0, 15);
            if (pick < 7) begin
                x.addr = BASE + 32'h100 + 32'(4 * word) + 32'($urandom_range(0, 3));
            end else if (pick == 7) begin
                x.addr = BASE - 32'(4 * (word + 1));
            end else if (pick == 8) begin
                x.addr = BASE + 32'h1000 + 32'(4 * word);
            end else begin
                x.addr = CON;
                x.size = 3'($urandom_range(0, 2));
            end
            predict(x, w, e, c);
            xq.push_back(x);
            exp_q.push_back(e);
            exp_chk_q.push_back(c);
        end
        drive_all();
        repeat (2) @(posedge clk);
        #1;
        compare_all(tag);
        compare_console(tag);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    vec_t tbl[$];
    int   exp_cycles;

    initial begin
        sel = 1'b0;
        bus_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hready0", 32'(bus0.hreadyout), 32'd1);
        check("rst_hresp0",  32'(bus0.hresp),     32'd0);
        check("rst_hrdata0", bus0.hrdata,         32'h0);
        check("rst_state0",  32'(dbg0),           32'd0);
        check("rst_hready3", 32'(bus3.hreadyout), 32'd1);
        check("rst_state3",  32'(dbg3),           32'd0);
`ifdef AHB_SRAM_CONSOLE_EN
        check("rst_con_valid", 32'(bus0.console_valid), 32'd0);
        check("rst_con_data",  32'(bus0.console_data),  32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- directed table on the zero-wait instance ----
        tbl.push_back(mk(1, 2, 32'h4000_0000, 32'hDEAD_BEEF, 32'h0,         2'b00, 0, 0));
        tbl.push_back(mk(0, 2, 32'h4000_0000, 32'h0,         32'hDEAD_BEEF, 2'b00, 0, 1));
        tbl.push_back(mk(1, 2, 32'h4000_0000, 32'h1122_3344, 32'h0,         2'b00, 0, 0));
        tbl.push_back(mk(1, 0, 32'h4000_0002, 32'h0055_0000, 32'h0,         2'b00, 0, 0));
        tbl.push_back(mk(0, 2, 32'h4000_0000, 32'h0,         32'h1155_3344, 2'b00, 0, 1));
        tbl.push_back(mk(1, 1, 32'h4000_0002, 32'hA5A5_0000, 32'h0,         2'b00, 0, 0));
        tbl.push_back(mk(0, 2, 32'h4000_0000, 32'h0,         32'hA5A5_3344, 2'b00, 0, 1));
        tbl.push_back(mk(0, 2, 32'h3FFF_FFFC, 32'h0,         32'h0,         2'b01, 1, 0));
        tbl.push_back(mk(0, 2, 32'h4000_0000, 32'h0,         32'hA5A5_3344, 2'b00, 0, 1));
        tbl.push_back(mk(0, 2, 32'h4000_0001, 32'h0,         32'h0,         2'b01, 1, 0));
        tbl.push_back(mk(0, 3, 32'h4000_0000, 32'h0,         32'h0,         2'b01, 1, 0));
        tbl.push_back(mk(0, 2, 32'h4000_0000, 32'h0,         32'hA5A5_3344, 2'b00, 0, 1));
        tbl.push_back(mk(1, 2, 32'h4000_0010, 32'h0BAD_F00D, 32'h0,         2'b00, 0, 0));
        tbl.push_back(mk(0, 2, 32'h4000_0010, 32'h0,         32'h0BAD_F00D, 2'b00, 0, 1));
        tbl.push_back(mk(1, 0, 32'h4000_0011, 32'h0000_7700, 32'h0,         2'b00, 0, 0));
        tbl.push_back(mk(0, 2, 32'h4000_0010, 32'h0,         32'h0BAD_770D, 2'b00, 0, 1));
        tbl.push_back(mk(1, 2, 32'h4000_0FFC, 32'hCAFE_F00D, 32'h0,         2'b00, 0, 0));
        tbl.push_back(mk(0, 2, 32'h4000_0FFC, 32'h0,         32'hCAFE_F00D, 2'b00, 0, 1));
        tbl.push_back(mk(0, 2, 32'h4000_1000, 32'h0,         32'h0,         2'b01, 1, 0));
        tbl.push_back(mk(1, 1, 32'h4000_0001, 32'hFFFF_FFFF, 32'h0,         2'b01, 1, 0));
        tbl.push_back(mk(0, 2, 32'h4000_0000, 32'h0,         32'hA5A5_3344, 2'b00, 0, 1));
        tbl.push_back(mk(0, 0, 32'h4000_0013, 32'h0,         32'h0BAD_770D, 2'b00, 0, 1));
        tbl.push_back(mk(0, 1, 32'h4000_0012, 32'h0,         32'h0BAD_770D, 2'b00, 0, 1));
`ifdef AHB_SRAM_CONSOLE_EN
        tbl.push_back(mk(1, 0, CON,           32'h4100_0000, 32'h0,         2'b00, 0, 0));
        tbl.push_back(mk(0, 0, CON,           32'h0,         32'h0,         2'b00, 0, 1));
        tbl.push_back(mk(1, 2, CON - 32'd3,   32'h0,         32'h0,         2'b01, 1, 0));
`else
        tbl.push_back(mk(1, 0, CON,           32'h4100_0000, 32'h0,         2'b01, 1, 0));
        tbl.push_back(mk(0, 0, CON,           32'h0,         32'h0,         2'b01, 1, 0));
`endif

        sel = 1'b0;
        xq.delete();
        exp_q.delete();
        exp_chk_q.delete();
        exp_cycles = 1;
        for (int k = 0; k < tbl.size(); k++) begin
            rsp_t e;
            e.rdata = tbl[k].rd;
            e.resp  = tbl[k].resp;
            e.waits = tbl[k].waits;
            xq.push_back(tbl[k].x);
            exp_q.push_back(e);
            exp_chk_q.push_back(tbl[k].chk_rd);
            exp_cycles += 1 + tbl[k].waits;
        end
        drive_all();
        repeat (2) @(posedge clk);
        #1;
        compare_all("tbl");
        check("tbl_cycles", 32'(last_cycles), 32'(exp_cycles));
`ifdef AHB_SRAM_CONSOLE_EN
        exp_con_q.push_back(8'h41);
        compare_console("tbl");
`endif

        // ---- wait-state instance: preset, single read, back-to-back reads ----
        sel = 1'b1;
        xq.delete();
        xq.push_back('{wr: 1'b1, size: 3'd2, addr: 32'h4000_0020, wdata: 32'h1234_5678});
        xq.push_back('{wr: 1'b1, size: 3'd2, addr: 32'h4000_0024, wdata: 32'h9ABC_DEF0});
        drive_all();
        check("w3_wr_waits", 32'(rq[0].waits), 32'd3);
        check("w3_wr_resp",  32'(rq[1].resp),  32'd0);

        xq.delete();
        xq.push_back('{wr: 1'b0, size: 3'd2, addr: 32'h4000_0020, wdata: 32'h0});
        drive_all();
        check("w3_single_waits", 32'(rq[0].waits), 32'd3);
        check("w3_single_rdata", rq[0].rdata, 32'h1234_5678);

        xq.delete();
        xq.push_back('{wr: 1'b0, size: 3'd2, addr: 32'h4000_0024, wdata: 32'h0});
        xq.push_back('{wr: 1'b0, size: 3'd2, addr: 32'h4000_0020, wdata: 32'h0});
        xq.push_back('{wr: 1'b0, size: 3'd2, addr: 32'h4000_0024, wdata: 32'h0});
        drive_all();
        check("w3_b2b_cycles", 32'(last_cycles), 32'd13);
        check("w3_b2b_rdata0", rq[0].rdata, 32'h9ABC_DEF0);
        check("w3_b2b_rdata1", rq[1].rdata, 32'h1234_5678);
        check("w3_b2b_waits2", 32'(rq[2].waits), 32'd3);

        // ---- reset in the middle of a waited write: write must be dropped ----
        hsel_d   = 1'b1;
        htrans_d = 2'b10;
        hwrite_d = 1'b1;
        hsize_d  = 3'd2;
        haddr_d  = 32'h4000_0020;
        @(posedge clk);
        #1;
        hsel_d   = 1'b0;
        htrans_d = 2'b00;
        hwdata_d = 32'hFFFF_FFFF;
        check("midwait_hready", 32'(bus3.hreadyout), 32'd0);
        check("midwait_state",  32'(dbg3),           32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_hready", 32'(bus3.hreadyout), 32'd1);
        check("async_rst_hresp",  32'(bus3.hresp),     32'd0);
        check("async_rst_state",  32'(dbg3),           32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus_idle();
        @(posedge clk);
        #1;
        xq.delete();
        xq.push_back('{wr: 1'b0, size: 3'd2, addr: 32'h4000_0020, wdata: 32'h0});
        drive_all();
        check("dropped_write_rdata", rq[0].rdata, 32'h1234_5678);

        // ---- random traffic against the model ----
        got_con_q.delete();
        exp_con_q.delete();
        random_run(1'b0, 0, "rnd_w0");
        random_run(1'b1, 3, "rnd_w3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
